// File: rtl/vx_writeback_arb_scalar_if.sv
// Execute-to-writeback bus for the per-slot writeback arbiter: NUM_SRCS result
// streams in per issue slot and one writeback stream out per slot (no ready).
interface vx_writeback_arb_scalar_if #(
  parameter int NUM_SRCS   = 3,
  parameter int THREAD_CNT = 4,
  parameter int ISSUE_CNT  = 2,
  parameter int WIS_W      = 2,
  parameter int XLEN       = 32,
  parameter int NR_BITS    = 5,
  parameter int UUID_W     = 44
);
  typedef struct packed {
    logic [UUID_W-1:0]                uuid;
    logic [WIS_W-1:0]                 wis;
    logic [THREAD_CNT-1:0]            tmask;
    logic [XLEN-1:0]                  PC;
    logic                             wb;
    logic [NR_BITS-1:0]               rd;
    logic [THREAD_CNT-1:0][XLEN-1:0]  data;
    logic                             sop;
    logic                             eop;
  } beat_t;

  logic  [ISSUE_CNT-1:0][NUM_SRCS-1:0] src_valid;
  logic  [ISSUE_CNT-1:0][NUM_SRCS-1:0] src_ready;
  beat_t [ISSUE_CNT-1:0][NUM_SRCS-1:0] src_data;
  logic  [ISSUE_CNT-1:0]               wb_valid;
  beat_t [ISSUE_CNT-1:0]               wb_data;

  // master: the arbiter (drives writeback); slave: execute units / consumer
  modport master (input src_valid, src_data, output src_ready, wb_valid, wb_data);
  modport slave  (output src_valid, src_data, input src_ready, wb_valid, wb_data);
endinterface

// File: rtl/vx_writeback_arb_scalar.sv
// Per-issue-slot round-robin writeback arbiter with packet locking: multi-beat
// packets are never interleaved, and the registered output stage has no backpressure.
`ifndef STALL_TIMEOUT
`define STALL_TIMEOUT 1000
`endif

module vx_writeback_arb_scalar #(
  parameter int CORE_ID    = 0,
  parameter int NUM_SRCS   = 3,
  parameter int THREAD_CNT = 4,
  parameter int ISSUE_CNT  = 2,
  parameter int WARP_CNT   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  vx_writeback_arb_scalar_if.master    bus,
  output logic [ISSUE_CNT-1:0][31:0]   perf_stalls
);
  localparam int            PW   = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;
  localparam logic [PW-1:0] LAST = PW'(NUM_SRCS - 1);

  if (NUM_SRCS < 1 || THREAD_CNT < 1 || WARP_CNT < ISSUE_CNT) begin : g_bad_cfg
    $error("vx_writeback_arb_scalar: invalid configuration");
  end

  logic [ISSUE_CNT-1:0][PW-1:0]       ptr, owner, gidx;
  logic [ISSUE_CNT-1:0]               locked, any;
  logic [ISSUE_CNT-1:0][NUM_SRCS-1:0] gnt;
  int                                 idx;

  // While locked only the owner may win, even if it is idle this cycle.
  always_comb begin
    gnt  = '0;
    gidx = '0;
    any  = '0;
    idx  = 0;
    for (int s = 0; s < ISSUE_CNT; s++) begin
      if (!reset) begin
        if (locked[s]) begin
          if (bus.src_valid[s][owner[s]]) begin
            gnt[s][owner[s]] = 1'b1;
            gidx[s]          = owner[s];
            any[s]           = 1'b1;
          end
        end else begin
          for (int i = 0; i < NUM_SRCS; i++) begin
            idx = (int'(ptr[s]) + i) % NUM_SRCS;
            if (!any[s] && bus.src_valid[s][idx]) begin
              gnt[s][idx] = 1'b1;
              gidx[s]     = PW'(idx);
              any[s]      = 1'b1;
            end
          end
        end
      end
    end
  end

  assign bus.src_ready = gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr          <= '0;
      owner        <= '0;
      locked       <= '0;
      perf_stalls  <= '0;
      bus.wb_valid <= '0;
      bus.wb_data  <= '0;
    end else begin
      for (int s = 0; s < ISSUE_CNT; s++) begin
        bus.wb_valid[s] <= any[s] && bus.src_data[s][gidx[s]].wb;
        if (any[s] && bus.src_data[s][gidx[s]].wb)
          bus.wb_data[s] <= bus.src_data[s][gidx[s]];
        if (any[s]) begin
          if (bus.src_data[s][gidx[s]].eop) begin
            locked[s] <= 1'b0;
            ptr[s]    <= (gidx[s] == LAST) ? '0 : gidx[s] + 1'b1;
          end else begin
            locked[s] <= 1'b1;
            owner[s]  <= gidx[s];
          end
        end
        if (|(bus.src_valid[s] & ~gnt[s]) && perf_stalls[s] != 32'hFFFF_FFFF)
          perf_stalls[s] <= perf_stalls[s] + 32'd1;
      end
    end
  end

`ifndef SYNTHESIS
  logic [ISSUE_CNT-1:0][31:0] lock_age;

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_age <= '0;
    end else begin
      for (int s = 0; s < ISSUE_CNT; s++) begin
        lock_age[s] <= locked[s] ? lock_age[s] + 32'd1 : 32'd0;
        if (any[s] && !locked[s])
          assert (bus.src_data[s][gidx[s]].sop)
            else $error("core%0d slot%0d: packet start without sop", CORE_ID, s);
        if (locked[s])
          assert (lock_age[s] < `STALL_TIMEOUT)
            else $error("core%0d slot%0d: lock held by src %0d past timeout", CORE_ID, s, owner[s]);
      end
    end
  end
`endif
endmodule
